// File: rtl/stats_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : stats_fifo_buf
// Brief    : Single-clock FIFO with standard or first-word-fall-through read,
//            write acknowledge, programmable full and saturating overflow count.
// Revision : 1.0 - initial release
// ============================================================================
module stats_fifo_buf #(
    parameter int C_WIDTH            = 448,
    parameter int C_FIFO_SIZE        = 1024,
    parameter int C_FWFT             = 0,
    parameter int C_PROG_FULL_THRESH = 1008
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [C_WIDTH-1:0]           din,
    input  logic                         wr_en,
    output logic                         full,
    output logic                         wr_ack,
    output logic [15:0]                  overflow_count,
    input  logic                         rd_en,
    output logic [C_WIDTH-1:0]           dout,
    output logic                         empty,
    output logic                         valid,
    output logic [$clog2(C_FIFO_SIZE):0] occupancy,
    output logic                         prog_full
);

    localparam int              c_aw  = $clog2(C_FIFO_SIZE);
    localparam int              c_ow  = c_aw + 1;
    localparam logic [c_ow-1:0] c_cap = c_ow'(C_FIFO_SIZE);
    localparam logic [c_ow-1:0] c_thr = c_ow'(C_PROG_FULL_THRESH);

    logic [C_WIDTH-1:0] r_mem [C_FIFO_SIZE];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_ow-1:0]    r_occ;
    logic               r_full;
    logic               r_prog_full;
    logic               r_empty_std;
    logic               r_valid;
    logic               r_wr_ack;
    logic [15:0]        r_ovf;
    logic [C_WIDTH-1:0] r_dout;

    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_load;
    logic [c_ow-1:0]    w_stored;
    logic [c_ow-1:0]    w_occ_next;

    // In FWFT mode occupancy includes the output register, so the words still
    // in RAM are occupancy minus the valid head; a RAM word is fetched whenever
    // the output register is free or being consumed this cycle.
    always_comb begin
        w_empty    = (C_FWFT != 0) ? ~r_valid : r_empty_std;
        w_wr_acc   = wr_en & ~r_full;
        w_rd_acc   = rd_en & ~w_empty;
        w_stored   = (C_FWFT != 0) ? (r_occ - c_ow'(r_valid)) : r_occ;
        w_load     = (C_FWFT != 0) ? ((w_stored != '0) && (!r_valid || w_rd_acc))
                                   : w_rd_acc;
        w_occ_next = r_occ + c_ow'(w_wr_acc) - c_ow'(w_rd_acc);
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_full      <= 1'b0;
            r_prog_full <= 1'b0;
            r_empty_std <= 1'b1;
            r_valid     <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_ovf       <= '0;
            r_dout      <= '0;
        end else begin
            r_wr_ack <= w_wr_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_occ       <= w_occ_next;
            r_full      <= (w_occ_next == c_cap);
            r_prog_full <= (w_occ_next >= c_thr);
            r_empty_std <= (w_occ_next == '0);
            if (wr_en && r_full && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
            if (C_FWFT != 0) begin
                if (w_load) begin
                    r_valid <= 1'b1;
                end else if (w_rd_acc) begin
                    r_valid <= 1'b0;
                end
            end else begin
                r_valid <= w_rd_acc;
            end
        end
    end

    assign full           = r_full;
    assign wr_ack         = r_wr_ack;
    assign overflow_count = r_ovf;
    assign dout           = r_dout;
    assign empty          = w_empty;
    assign valid          = r_valid;
    assign occupancy      = r_occ;
    assign prog_full      = r_prog_full;

endmodule
`default_nettype wire

// File: tb/tb_stats_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_stats_fifo_buf
// Brief    : Scoreboard bench driving a standard-mode and a FWFT instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stats_fifo_buf;

    localparam int c_w      = 16;
    localparam int c_s_size = 4;
    localparam int c_s_thr  = 3;
    localparam int c_f_size = 8;
    localparam int c_f_thr  = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic           rd_en;
    logic [c_w-1:0] din;

    logic           s_full, s_ack, s_empty, s_valid, s_pf;
    logic [15:0]    s_ovf;
    logic [c_w-1:0] s_dout;
    logic [2:0]     s_occ;
    logic           f_full, f_ack, f_empty, f_valid, f_pf;
    logic [15:0]    f_ovf;
    logic [c_w-1:0] f_dout;
    logic [3:0]     f_occ;

    always #5 clk = ~clk;

    stats_fifo_buf #(.C_WIDTH(c_w), .C_FIFO_SIZE(c_s_size), .C_FWFT(0),
                     .C_PROG_FULL_THRESH(c_s_thr)) u_std (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(s_full),
        .wr_ack(s_ack), .overflow_count(s_ovf), .rd_en(rd_en), .dout(s_dout),
        .empty(s_empty), .valid(s_valid), .occupancy(s_occ), .prog_full(s_pf));

    stats_fifo_buf #(.C_WIDTH(c_w), .C_FIFO_SIZE(c_f_size), .C_FWFT(1),
                     .C_PROG_FULL_THRESH(c_f_thr)) u_fwft (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(f_full),
        .wr_ack(f_ack), .overflow_count(f_ovf), .rd_en(rd_en), .dout(f_dout),
        .empty(f_empty), .valid(f_valid), .occupancy(f_occ), .prog_full(f_pf));

    // Reference model: a queue of stored words; FWFT words carry the cycle they
    // were written, since the head only becomes visible two cycles later.
    typedef struct packed { logic [c_w-1:0] d; int wc; } ent_t;
    logic [c_w-1:0] qs[$];
    ent_t           qf[$];
    logic [c_w-1:0] sbs[$];
    logic [c_w-1:0] sbf[$];
    int             cyc = 0;
    int             s_ov = 0, f_ov = 0;
    logic           s_wr_prev = 1'b0, s_rd_prev = 1'b0, f_wr_prev = 1'b0;
    logic [c_w-1:0] s_last = '0, f_disp = '0;

    int e_s_occ, e_s_full, e_s_pf, e_s_empty, e_s_valid, e_s_ack, e_s_ov, e_s_dout;
    int e_f_occ, e_f_full, e_f_pf, e_f_empty, e_f_valid, e_f_ack, e_f_ov, e_f_dout;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;
    logic done = 1'b0;
    logic fin_chk = 1'b0;

    task automatic model_eval();
        logic wa, ra, vis;
        ent_t e;
        e_s_occ = qs.size();  e_s_full = int'(qs.size() == c_s_size);
        e_s_pf  = int'(qs.size() >= c_s_thr); e_s_empty = int'(qs.size() == 0);
        e_s_valid = int'(s_rd_prev); e_s_ack = int'(s_wr_prev);
        e_s_ov = s_ov; e_s_dout = int'(s_last);
        if (rst) begin
            qs.delete(); s_ov = 0; s_wr_prev = 1'b0; s_rd_prev = 1'b0; s_last = '0;
        end else begin
            wa = wr_en && (qs.size() < c_s_size);
            ra = rd_en && (qs.size() != 0);
            if (wr_en && !wa && s_ov < 65535) s_ov++;
            if (ra) begin
                s_last = qs.pop_front();
                sbs.push_back(s_last);
            end
            if (wa) qs.push_back(din);
            s_wr_prev = wa; s_rd_prev = ra;
        end

        vis = (qf.size() != 0) && (qf[0].wc <= cyc - 2);
        if (vis) f_disp = qf[0].d;
        e_f_occ = qf.size();  e_f_full = int'(qf.size() == c_f_size);
        e_f_pf  = int'(qf.size() >= c_f_thr); e_f_valid = int'(vis);
        e_f_empty = int'(!vis); e_f_ack = int'(f_wr_prev);
        e_f_ov = f_ov; e_f_dout = int'(f_disp);
        if (rst) begin
            qf.delete(); f_ov = 0; f_wr_prev = 1'b0; f_disp = '0;
        end else begin
            wa = wr_en && (qf.size() < c_f_size);
            ra = rd_en && vis;
            if (wr_en && !wa && f_ov < 65535) f_ov++;
            if (ra) begin
                e = qf.pop_front();
                sbf.push_back(e.d);
            end
            if (wa) begin
                e.d = din; e.wc = cyc;
                qf.push_back(e);
            end
            f_wr_prev = wa;
        end
        cyc++;
    endtask

    task automatic step(input int w, input int r, input int rs, input int d);
        @(posedge clk);
        #1;
        wr_en = (w != 0); rd_en = (r != 0); rst = (rs != 0); din = c_w'(d);
        model_eval();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic miss(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT presented a word but none was expected (t=%0t)", nm, $time);
    endtask

    // Monitor: per-cycle flag check plus scoreboard pop on each presented word.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_occupancy", 32'(s_occ), e_s_occ);
            chk("s_full", 32'(s_full), e_s_full);
            chk("s_prog_full", 32'(s_pf), e_s_pf);
            chk("s_empty", 32'(s_empty), e_s_empty);
            chk("s_valid", 32'(s_valid), e_s_valid);
            chk("s_wr_ack", 32'(s_ack), e_s_ack);
            chk("s_overflow", 32'(s_ovf), e_s_ov);
            chk("s_dout", 32'(s_dout), e_s_dout);
            chk("f_occupancy", 32'(f_occ), e_f_occ);
            chk("f_full", 32'(f_full), e_f_full);
            chk("f_prog_full", 32'(f_pf), e_f_pf);
            chk("f_empty", 32'(f_empty), e_f_empty);
            chk("f_valid", 32'(f_valid), e_f_valid);
            chk("f_wr_ack", 32'(f_ack), e_f_ack);
            chk("f_overflow", 32'(f_ovf), e_f_ov);
            chk("f_dout", 32'(f_dout), e_f_dout);
            if (s_valid === 1'b1) begin
                if (sbs.size() == 0) miss("s_rdata");
                else chk("s_rdata", 32'(s_dout), 32'(sbs.pop_front()));
            end
            if (f_valid === 1'b1 && rd_en === 1'b1) begin
                if (sbf.size() == 0) miss("f_rdata");
                else chk("f_rdata", 32'(f_dout), 32'(sbf.pop_front()));
            end
            if (done && !fin_chk) begin
                chk("s_sb_left", sbs.size(), 0);
                chk("f_sb_left", sbf.size(), 0);
                fin_chk = 1'b1;
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk_en = 1'b1;
        step(0, 0, 0, 0);

        // Back-to-back A..D, one extra write, then reads
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'hA0 + i);
        step(1, 0, 0, 32'h55);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        drain();

        // Fill, hold wr_en while full, then simultaneous write+read while full
        for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h100 + i);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'hBAD);
        step(1, 1, 0, 32'hBEE);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        drain();

        // Single write into empty, read two cycles later; write+read while empty
        step(0, 0, 0, 0);
        step(1, 0, 0, 32'h5A5A);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 32'h1234);
        step(0, 0, 0, 0);
        drain();

        // Reset mid-operation with wr_en asserted
        step(1, 0, 0, 32'h11);
        step(1, 0, 0, 32'h22);
        step(1, 0, 1, 32'h33);
        step(1, 0, 0, 32'h44);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        drain();

        // Random bursts with varied write/read densities
        for (int b = 0; b < 10; b++) begin
            int len, pw, pr;
            len = int'($urandom_range(20, 80));
            pw  = int'($urandom_range(20, 90));
            pr  = int'($urandom_range(20, 90));
            for (int i = 0; i < len; i++) begin
                step(int'($urandom_range(0, 99) < pw), int'($urandom_range(0, 99) < pr),
                     0, int'($urandom));
            end
        end
        drain();

        // Overflow counter saturation
        for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h200 + i);
        for (int i = 0; i < 70000; i++) step(1, 0, 0, 32'hDEAD);
        drain();
        step(0, 0, 0, 0);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
